// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator side of a combinational ALU. It owns an 8x32
// register file with a hardwired-zero r0. It accepts one command at a time
// over a valid/ready channel, drives the ALU for exactly one cycle, writes the
// result back and returns the result and flags over a valid/ready response.
module alu_sequencer #(
    parameter int NREGS = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_rs,
    input  logic [2:0]       cmd_rt,
    input  logic             ld_en,
    input  logic [2:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_operand0,
    output logic [WIDTH-1:0] alu_operand1,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_Z,
    input  logic             alu_V,
    input  logic             alu_C,
    input  logic             alu_N,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SLT = 3'd6,
        OP_SLL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rf [NREGS];
    op_e              op_q;
    logic [2:0]       rd_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [3:0]       flags_q;
    logic             accept;
    logic             exec_wb;

    // Reset dominates in every register below, so acceptance need not look at it.
    assign accept  = (state_q == IDLE) && cmd_valid;
    // NOP produces nothing to store, and r0 is hardwired to zero.
    assign exec_wb = (state_q == EXEC) && (op_q != OP_NOP) && (rd_q != 3'd0);
    assign busy    = (state_q != IDLE);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, handshake outputs and the ALU drive (operands only in EXEC).
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_operand0 = '0;
        alu_operand1 = '0;
        alu_control  = OP_NOP;
        case (state_q)
            IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && !reset) state_d = EXEC;
            end
            EXEC: begin
                alu_operand0 = opa_q;
                alu_operand1 = opb_q;
                alu_control  = op_q;
                state_d      = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the accepted command, reading the register file as it stood before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_NOP;
            rd_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(cmd_op);
            rd_q  <= cmd_rd;
            opa_q <= rf[cmd_rs];
            opb_q <= rf[cmd_rt];
        end
    end

    // Capture the response at the end of EXEC; only ADD/SUB update the flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            flags_q    <= '0;
        end else if (state_q == EXEC) begin
            if (op_q == OP_NOP) begin
                rsp_result <= '0;
                rsp_flags  <= flags_q;
            end else begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_Z, alu_V, alu_C, alu_N};
            end
            if (op_q == OP_ADD || op_q == OP_SUB)
                flags_q <= {alu_Z, alu_V, alu_C, alu_N};
        end
    end

    // Register file: direct load port plus ALU write-back; r0 is never written.
    // NOTE: the array is deliberately on the async reset, because the block
    // must leave reset with every register at zero. That choice keeps it in
    // flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (ld_en && ld_addr != 3'd0) rf[ld_addr] <= ld_data;
            // Placed after the load, so the ALU write-back wins an address collision.
            if (exec_wb) rf[rd_q] <= alu_result;
        end
    end

endmodule
